// File: rtl/wb_burst_master.sv
// Wishbone classic burst initiator: one command at a time, incrementing
// word addresses, write data in and read data out on valid/ready streams,
// with a per-beat ACK timeout.
module wb_burst_master #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_adr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_we_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      rd_data_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_BEAT, S_RHOLD} state_t;

    state_t           state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic             we_q, we_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rd_q, rd_d;
    logic             cyc_q, cyc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // State and datapath registers; reset drops the bus immediately with no status pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            to_q    <= '0;
            dat_q   <= '0;
            rd_q    <= '0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            dat_q   <= dat_d;
            rd_q    <= rd_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the beat counter and address advance only when the next beat is committed.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        dat_d   = dat_q;
        rd_d    = rd_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d = cmd_adr_i & 32'hFFFF_FFFC;
                    cnt_d = cmd_len_i;
                    we_d  = cmd_we_i;
                    to_d  = '0;
                    if (cmd_we_i) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_BEAT;
                        cyc_d   = 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (wr_valid_i) begin
                    dat_d   = wr_data_i;
                    state_d = S_BEAT;
                    cyc_d   = 1'b1;
                    to_d    = '0;
                end
            end
            S_BEAT: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    if (!we_q) begin
                        rd_d    = wbm_dat_i;
                        state_d = S_RHOLD;
                    end else if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WDATA;
                        cnt_d   = cnt_q - LEN_W'(1);
                        adr_d   = adr_q + 32'd4;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_RHOLD: begin
                if (rd_ready_i) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BEAT;
                        cnt_d   = cnt_q - LEN_W'(1);
                        adr_d   = adr_q + 32'd4;
                        to_d    = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // Handshake outputs decode straight from the state register; cmd_ready is held low during reset.
    assign cmd_ready_o = (state_q == S_IDLE) & ~wb_rst_i;
    assign wr_ready_o  = (state_q == S_WDATA);
    assign rd_valid_o  = (state_q == S_RHOLD);
    assign rd_data_o   = rd_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = (state_q == S_BEAT);
    assign wbm_we_o    = (state_q == S_BEAT) & we_q;
    assign wbm_sel_o   = {4{state_q == S_BEAT}};
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a randomized slave, write source and
// read sink drive the DUT; a monitor checks every bus beat, read transfer and
// completion against expectations queued when each command is issued.
module tb_wb_burst_master;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready_o;
    logic [31:0]      cmd_adr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_we = 1'b0;
    logic             wr_valid;
    logic             wr_ready_o;
    logic [31:0]      wr_data;
    logic             rd_valid_o;
    logic             rd_ready;
    logic [31:0]      rd_data_o;
    logic             done_o, err_o;
    logic             cyc_o, stb_o, we_o;
    logic [3:0]       sel_o;
    logic [31:0]      adr_o, dat_o;
    logic [31:0]      s_dat;
    logic             s_ack;

    always #5 clk = ~clk;

    wb_burst_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr),
        .cmd_len_i(cmd_len), .cmd_we_i(cmd_we),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_data_o(rd_data_o),
        .done_o(done_o), .err_o(err_o),
        .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
        .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_dat_i(s_dat), .wbm_ack_i(s_ack)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    bit          end_q[$];   // 0 = done expected, 1 = err expected

    int nchk = 0;
    int nerr = 0;

    // Environment knobs
    int ack_lat      = -1;   // <0: random 0..4 cycles
    bit no_ack       = 1'b0;
    bit spur         = 1'b0;
    int wr_gap       = -1;   // <0: random 0..2 cycles
    int rd_stall_idx = -1;
    int rd_cnt       = 0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Slave: ACK after a per-beat latency, optional spurious ACK while STB is low.
    initial begin
        int cnt, lat;
        cnt = 0; lat = 0;
        s_ack = 1'b0; s_dat = '0;
        forever begin
            @(negedge clk);
            if (stb_o) begin
                if (cnt == 0) lat = (ack_lat < 0) ? int'($urandom_range(0, 4)) : ack_lat;
                s_ack = !no_ack && (cnt >= lat);
                cnt++;
            end else begin
                cnt = 0;
                s_ack = spur && ($urandom_range(0, 1) == 1);
            end
            s_dat = rd_fn(adr_o);
        end
    end

    // Write data source with gaps after each accepted word.
    initial begin
        int gap;
        gap = 0;
        wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge clk);
            if (gap > 0) begin
                gap--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
            end
            #1;
            if (wr_valid && wr_ready_o && !rst && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                gap = (wr_gap < 0) ? int'($urandom_range(0, 2)) : wr_gap;
            end
        end
    end

    // Read sink: random back-pressure, plus a 3-cycle stall on a chosen transfer.
    initial begin
        int stall;
        stall = 0;
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_valid_o && rd_cnt == rd_stall_idx) begin
                stall = 3;
                rd_stall_idx = -1;
            end
            if (stall > 0) begin
                rd_ready = 1'b0;
                stall--;
            end else begin
                rd_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (rd_valid_o && rd_ready && !rst) rd_cnt++;
        end
    end

    // Monitor: samples mid-cycle; every event seen here takes effect at the next rising edge.
    initial begin
        logic        p_stb, p_ack, p_rdv, p_rdy, p_rst, p_we, launch, in_burst, stb_rise;
        logic [31:0] p_adr, p_rdd;
        logic [3:0]  p_sel;
        int          run, last_run;
        beat_t       e;
        p_stb = 0; p_ack = 0; p_rdv = 0; p_rdy = 0; p_rst = 1; p_we = 0;
        launch = 0; in_burst = 0; p_adr = '0; p_rdd = '0; p_sel = '0;
        run = 0; last_run = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (p_rst) begin
                    chk("reset_ctrl", 32'({cmd_ready_o, wr_ready_o, rd_valid_o, done_o, err_o,
                                           cyc_o, stb_o, we_o, sel_o}), 32'h0);
                    chk("reset_adr", adr_o, 32'h0);
                    chk("reset_dat", dat_o, 32'h0);
                    chk("reset_rdata", rd_data_o, 32'h0);
                end
                p_rst = 1; p_stb = 0; p_ack = 0; p_rdv = 0; p_rdy = 0;
                launch = 0; in_burst = 0; run = 0;
            end else begin
                stb_rise = stb_o && !p_stb;
                chk("stb_launch", 32'(stb_rise), 32'(launch));
                if (p_stb && p_ack) chk("stb_drop_after_ack", 32'(stb_o), 32'h0);
                if (p_stb && !p_ack && stb_o) begin
                    chk("adr_stable", adr_o, p_adr);
                    chk("we_sel_stable", 32'({we_o, sel_o}), 32'({p_we, p_sel}));
                end
                if (p_rdv && !p_rdy) begin
                    chk("rd_valid_held", 32'(rd_valid_o), 32'h1);
                    chk("rd_data_held", rd_data_o, p_rdd);
                end
                launch = 0;
                if (cmd_valid && cmd_ready_o && !cmd_we) launch = 1;
                if (wr_valid && wr_ready_o) launch = 1;
                if (stb_o && s_ack) begin
                    if (beat_q.size() == 0) fail_now("unexpected_beat");
                    else begin
                        e = beat_q.pop_front();
                        chk("beat_adr", adr_o, e.adr);
                        chk("beat_we", 32'(we_o), 32'(e.we));
                        chk("beat_sel", 32'(sel_o), 32'hF);
                        if (e.we) chk("beat_wdat", dat_o, e.dat);
                    end
                end
                if (rd_valid_o && rd_ready) begin
                    if (rd_q.size() == 0) fail_now("unexpected_rdata");
                    else chk("rd_data", rd_data_o, rd_q.pop_front());
                    if (beat_q.size() > 0) launch = 1;
                end
                if (stb_o) run++;
                else begin
                    if (run > 0) last_run = run;
                    run = 0;
                end
                if (done_o || err_o) begin
                    chk("done_err_excl", 32'(done_o & err_o), 32'h0);
                    if (end_q.size() == 0) fail_now("unexpected_end");
                    else chk("end_kind_err", 32'(err_o), 32'(end_q.pop_front()));
                    chk("end_cmd_ready", 32'(cmd_ready_o), 32'h1);
                    if (err_o) chk("timeout_stb_cycles", 32'(last_run), 32'(TIMEOUT));
                    in_burst = 0;
                end
                chk("cyc", 32'(cyc_o), 32'(in_burst || stb_o));
                if (stb_o) in_burst = 1;
                p_rst = 0; p_stb = stb_o; p_ack = s_ack; p_rdv = rd_valid_o; p_rdy = rd_ready;
                p_adr = adr_o; p_we = we_o; p_sel = sel_o; p_rdd = rd_data_o;
            end
        end
    end

    // Queue the reference outcome of a command, then present it for one cycle (DUT is idle).
    task automatic issue(input logic [31:0] adr, input int len, input bit we,
                         input bit expect_err, input logic [31:0] d0);
        logic [31:0] a;
        a = adr & 32'hFFFF_FFFC;
        if (!expect_err) begin
            for (int n = 0; n <= len; n++) begin
                beat_t b;
                b.adr = a + 32'(4 * n);
                b.we  = we;
                b.dat = we ? d0 + 32'(n) * 32'h0101_0101 : 32'h0;
                beat_q.push_back(b);
                if (we) wr_q.push_back(b.dat);
                else    rd_q.push_back(rd_fn(b.adr));
            end
        end
        end_q.push_back(expect_err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_adr   = adr;
        cmd_len   = LEN_W'(len);
        cmd_we    = we;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_len   = LEN_W'($urandom);
        cmd_we    = 1'b0;
    endtask

    task automatic flush_reset();
        @(negedge clk);
        rst = 1'b1;
        beat_q.delete(); rd_q.delete(); wr_q.delete(); end_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int i;
        for (i = 0; i < 400 && end_q.size() > 0; i++) begin
            @(negedge clk);
            #3;
        end
        if (end_q.size() > 0) begin
            fail_now({nm, "_no_completion"});
            flush_reset();
        end else begin
            chk({nm, "_leftover"}, 32'(beat_q.size() + rd_q.size() + wr_q.size()), 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'h1);
        chk("idle_cyc_done", 32'({cyc_o, done_o, err_o}), 32'h0);

        // Single write
        ack_lat = 1; wr_gap = 0;
        issue(32'h3000_0000, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        wait_end("single_write");

        // 4-beat read with 3-cycle stall on beat 2
        ack_lat = 2; rd_stall_idx = rd_cnt + 1;
        issue(32'h3000_0100, 3, 1'b0, 1'b0, 32'h0);
        wait_end("read4_stall");

        // Timeout: slave never answers
        no_ack = 1'b1;
        issue(32'h5000_0000, 2, 1'b0, 1'b1, 32'h0);
        wait_end("timeout");
        no_ack = 1'b0;

        // Address wrap
        ack_lat = -1;
        issue(32'hFFFF_FFF8, 3, 1'b0, 1'b0, 32'h0);
        wait_end("wrap");

        // Reset during beat 2 of a 4-beat write, then a normal 1-beat read
        ack_lat = 6;
        issue(32'h4000_0000, 3, 1'b1, 1'b0, 32'hA000_0001);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (beat_q.size() == 3 && stb_o) break;
        end
        if (i == 200) fail_now("reset_beat2_not_reached");
        flush_reset();
        @(negedge clk);
        #3;
        chk("post_reset_cmd_ready", 32'(cmd_ready_o), 32'h1);
        ack_lat = -1;
        issue(32'h4000_0040, 0, 1'b0, 1'b0, 32'h0);
        wait_end("post_reset_read");

        // Write stalls between beats plus spurious ACKs
        wr_gap = 5; spur = 1'b1;
        issue(32'h6000_0012, 2, 1'b1, 1'b0, 32'h1234_0000);
        wait_end("stall_spur");
        wr_gap = -1;

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            bit we, terr;
            we   = $urandom_range(0, 1) == 1;
            terr = !we && ($urandom_range(0, 7) == 0);
            spur = $urandom_range(0, 1) == 1;
            no_ack = terr;
            issue($urandom, int'($urandom_range(0, 7)), we, terr, $urandom);
            wait_end("random");
            no_ack = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("final_queues_empty", 32'(beat_q.size() + rd_q.size() + wr_q.size() + end_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
